// File: rtl/bram_read_ctrl.sv
// rtl/bram_read_ctrl.sv - burst read controller streaming BRAM words through a 2-entry buffer
//
// Purpose: on start, reads len consecutive words (address wraps at 2**ADDR_W)
// from a synchronous-read BRAM and streams them to a valid/ready consumer.
// Reads are only issued when the output buffer is guaranteed to have room
// for the returning word, so nothing is ever dropped under backpressure.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - burst request (sampled in IDLE only)
//   base_addr  - first word address, sampled with start
//   len        - word count 0..2**ADDR_W, sampled with start
//   busy       - controller not idle
//   done       - one-cycle burst-complete pulse
//   bram_en    - BRAM read enable, one cycle per word
//   bram_addr  - BRAM read address
//   bram_dout  - BRAM read data, one cycle after bram_en
//   rd_data    - streamed word
//   rd_valid   - rd_data valid
//   rd_ready   - consumer accept
module bram_read_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE  = 1;
  localparam logic [ADDR_W:0]   REM_ZERO = 0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                inflight_q, inflight_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fifo_mem_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic [1:0]          occ;
  logic                issue;
  logic                drain_done;
  logic                pop;
  logic                bypass;
  logic                fifo_we;

  // Words already owed to the buffer: stored ones plus the one in flight.
  assign occ = count_q + {1'b0, inflight_q};

  // A word returning from BRAM is visible to the consumer in the same cycle;
  // if it is taken right away it never needs a buffer slot.
  assign rd_valid = (count_q != 2'd0) | inflight_q;
  assign pop      = rd_valid & rd_ready;
  assign bypass   = (count_q == 2'd0) & inflight_q & rd_ready;
  assign fifo_we  = inflight_q & ~bypass;

  always_comb begin
    rd_data = '0;
    if (count_q != 2'd0) begin
      rd_data = fifo_mem_q[rd_ptr_q];
    end else if (inflight_q) begin
      rd_data = bram_dout;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != REM_ZERO) begin
            state_d = S_ISSUE;
            addr_d  = base_addr;
            rem_d   = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // Only issue when the returning word is certain to find a slot.
        if (rem_q != REM_ZERO && occ < 2'd2) begin
          issue      = 1'b1;
          addr_d     = addr_q + ADDR_ONE;
          rem_d      = rem_q - REM_ONE;
          inflight_d = 1'b1;
          if (rem_q == REM_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == 2'd0 && !inflight_q) begin
          state_d    = S_IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ fifo_we;
    rd_ptr_d = rd_ptr_q ^ (pop & ~bypass);
    count_d  = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q | drain_done;
  assign bram_en   = issue;
  assign bram_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      inflight_q    <= 1'b0;
      done_q        <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (fifo_we) begin
        fifo_mem_q[wr_ptr_q] <= bram_dout;
      end
    end
  end

endmodule

// File: tb/tb_bram_read_ctrl.sv
// tb/tb_bram_read_ctrl.sv - self-checking bench for bram_read_ctrl
module tb_bram_read_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] len;
  logic        busy;
  logic        done;
  logic        bram_en;
  logic [12:0] bram_addr;
  logic [31:0] bram_dout;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_read_ctrl #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready)
  );

  // BRAM model: mem[i] = i + 100, synchronous read.
  initial bram_dout = 32'd0;
  always @(posedge clk) begin
    if (bram_en) bram_dout <= 32'(bram_addr) + 32'd100;
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic [12:0] base;
    logic [13:0] len;
    logic        rr;
    logic        busy;
    logic        done;
    logic        en;
    logic [12:0] addr;
    logic        valid;
    logic [31:0] data;
    logic        chk_all;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t v(logic r, logic s, logic [12:0] b, logic [13:0] l, logic rr,
                             logic bz, logic dn, logic en, logic [12:0] a, logic vl,
                             logic [31:0] d, logic ca);
    vec_t x;
    x.rst = r; x.start = s; x.base = b; x.len = l; x.rr = rr;
    x.busy = bz; x.done = dn; x.en = en; x.addr = a; x.valid = vl;
    x.data = d; x.chk_all = ca;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_burst(input logic [12:0] base, input logic [13:0] l,
                           input bit stall, input bit intrude, input string tag);
    int          occ;
    int          done_cnt;
    int          tail;
    bit          finished;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [12:0] addrs[$];
    logic [31:0] datas[$];
    logic [3:0]  pat;
    logic [12:0] ea;
    occ = 0; done_cnt = 0; tail = 0; finished = 0; prev_stall = 0; prev_data = 0;
    pat = 4'b1001;
    @(negedge clk);
    rst = 0; start = 1; base_addr = base; len = l; rd_ready = 1;
    for (int cyc = 0; cyc < 200 && tail < 3; cyc++) begin
      @(negedge clk);
      rd_ready  = stall ? pat[3 - (cyc % 4)] : 1'b1;
      start     = intrude && (cyc == 1);
      base_addr = intrude ? 13'd0 : base;
      len       = 14'd5;
      #1;
      if (prev_stall) begin
        chk({tag, " stall_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, " stall_data"}, rd_data, prev_data);
      end
      if (bram_en) begin
        addrs.push_back(bram_addr);
        chk({tag, " credit"}, 32'(occ < 2), 32'd1);
      end
      if (rd_valid && rd_ready) datas.push_back(rd_data);
      if (finished) begin
        tail++;
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " idle_en"}, 32'(bram_en), 32'd0);
        chk({tag, " idle_valid"}, 32'(rd_valid), 32'd0);
      end
      if (done) begin
        done_cnt++;
        finished = 1;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      occ = occ + int'(bram_en) - int'(rd_valid && rd_ready);
    end
    start = 0;
    chk({tag, " finished"}, 32'(finished), 32'd1);
    chk({tag, " done_cnt"}, done_cnt, 32'd1);
    chk({tag, " n_addr"}, addrs.size(), 32'(l));
    chk({tag, " n_data"}, datas.size(), 32'(l));
    for (int i = 0; i < int'(l); i++) begin
      ea = base + 13'(i);
      if (i < addrs.size()) chk({tag, " addr"}, 32'(addrs[i]), 32'(ea));
      if (i < datas.size()) chk({tag, " data"}, datas[i], 32'(ea) + 32'd100);
    end
  endtask

  initial begin
    // rst start base len rr | busy done en addr valid data chk_all
    vt[0]  = v(0, 0, 0,  0, 1,  0, 0, 0, 0, 0, 0,   1);
    vt[1]  = v(0, 1, 0,  4, 1,  0, 0, 0, 0, 0, 0,   0);
    vt[2]  = v(0, 0, 0,  0, 1,  1, 0, 1, 0, 0, 0,   0);
    vt[3]  = v(0, 0, 0,  0, 1,  1, 0, 1, 1, 1, 100, 0);
    vt[4]  = v(0, 0, 0,  0, 1,  1, 0, 1, 2, 1, 101, 0);
    vt[5]  = v(0, 0, 0,  0, 1,  1, 0, 1, 3, 1, 102, 0);
    vt[6]  = v(0, 0, 0,  0, 1,  1, 0, 0, 0, 1, 103, 0);
    vt[7]  = v(0, 0, 0,  0, 1,  1, 1, 0, 0, 0, 0,   0);
    vt[8]  = v(0, 0, 0,  0, 1,  0, 0, 0, 0, 0, 0,   0);
    vt[9]  = v(0, 1, 5,  0, 1,  0, 0, 0, 0, 0, 0,   0);
    vt[10] = v(0, 0, 0,  0, 1,  0, 1, 0, 0, 0, 0,   0);
    vt[11] = v(0, 0, 0,  0, 1,  0, 0, 0, 0, 0, 0,   0);
    vt[12] = v(0, 1, 0,  6, 1,  0, 0, 0, 0, 0, 0,   0);
    vt[13] = v(0, 0, 0,  0, 1,  1, 0, 1, 0, 0, 0,   0);
    vt[14] = v(0, 0, 0,  0, 1,  1, 0, 1, 1, 1, 100, 0);
    vt[15] = v(0, 0, 0,  0, 1,  1, 0, 1, 2, 1, 101, 0);
    vt[16] = v(1, 0, 0,  0, 1,  1, 0, 1, 3, 1, 102, 0);
    vt[17] = v(0, 0, 0,  0, 1,  0, 0, 0, 0, 0, 0,   1);
    vt[18] = v(0, 1, 10, 2, 1,  0, 0, 0, 0, 0, 0,   0);
    vt[19] = v(0, 0, 0,  0, 1,  1, 0, 1, 10, 0, 0,  0);
    vt[20] = v(0, 0, 0,  0, 1,  1, 0, 1, 11, 1, 110, 0);
    vt[21] = v(0, 0, 0,  0, 1,  1, 0, 0, 0, 1, 111, 0);
    vt[22] = v(0, 0, 0,  0, 1,  1, 1, 0, 0, 0, 0,   0);
    vt[23] = v(0, 0, 0,  0, 1,  0, 0, 0, 0, 0, 0,   0);

    rst = 1; start = 0; base_addr = 0; len = 0; rd_ready = 1;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst = vt[i].rst; start = vt[i].start; base_addr = vt[i].base;
      len = vt[i].len; rd_ready = vt[i].rr;
      #1;
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vt[i].done));
      chk($sformatf("v%0d bram_en", i), 32'(bram_en), 32'(vt[i].en));
      chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vt[i].valid));
      if (vt[i].en || vt[i].chk_all)
        chk($sformatf("v%0d bram_addr", i), 32'(bram_addr), 32'(vt[i].addr));
      if (vt[i].valid || vt[i].chk_all)
        chk($sformatf("v%0d rd_data", i), rd_data, vt[i].data);
    end

    run_burst(13'd8190, 14'd4, 1'b0, 1'b0, "wrap");
    run_burst(13'd20,   14'd8, 1'b1, 1'b0, "stall");
    run_burst(13'd40,   14'd3, 1'b0, 1'b1, "busy_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
